regwrite_arbiter: RTL

REGWRITE_ARBITER -- requirements
Module: regwrite_arbiter

---
 rtl/regwrite_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/regwrite_arbiter.sv
// Register-file write-port arbiter: pipeline writer A has priority, secondary writer B is queued
// in a small FIFO and given a forced slot once it has lost STARVE_LIMIT times in a row.
// Optional store-to-load bypass from the FIFO is enabled by defining REGARB_FORWARD_EN.
module regwrite_arbiter #(
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        A_VALID,
    input  logic [3:0]  A_ADDR,
    input  logic [15:0] A_DATA,
    input  logic        B_VALID,
    input  logic [3:0]  B_ADDR,
    input  logic [15:0] B_DATA,
    output logic        B_READY,
    output logic        STALL,
    output logic        W_ON,
    output logic [3:0]  WADDR,
    output logic [15:0] DATA_OUT,
    output logic        ENDWRITE,
    output logic [3:0]  ENDREG
`ifdef REGARB_FORWARD_EN
    ,
    input  logic [3:0]  RADDR,
    output logic        BYP_HIT,
    output logic [15:0] BYP_DATA
`endif
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic {StNormal, StForce} state_e;

    state_e            state_q, state_d;
    logic [3:0]        starve_q, starve_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [3:0]        fifo_addr_q [FIFO_DEPTH];
    logic [3:0]        fifo_addr_d [FIFO_DEPTH];
    logic [15:0]       fifo_data_q [FIFO_DEPTH];
    logic [15:0]       fifo_data_d [FIFO_DEPTH];
    logic              w_on_q, w_on_d;
    logic [3:0]        waddr_q, waddr_d;
    logic [15:0]       data_out_q, data_out_d;
    logic [3:0]        endreg_q, endreg_d;

    logic              fifo_empty;
    logic              b_ready;
    logic              push;
    logic              pop;
    logic              issue;
    logic [3:0]        iss_addr;
    logic [15:0]       iss_data;

    assign fifo_empty = (count_q == '0);
    assign b_ready    = (count_q != CntW'(FIFO_DEPTH));
    assign push       = B_VALID && b_ready;

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        pop         = 1'b0;
        issue       = 1'b0;
        iss_addr    = '0;
        iss_data    = '0;

        unique case (state_q)
            StNormal: begin
                if (A_VALID) begin
                    issue    = 1'b1;
                    iss_addr = A_ADDR;
                    iss_data = A_DATA;
                    if (!fifo_empty) begin
                        starve_d = 4'(starve_q + 4'd1);
                        if (starve_d >= 4'(STARVE_LIMIT)) begin
                            state_d = StForce;
                        end
                    end else begin
                        starve_d = '0;
                    end
                end else begin
                    pop      = !fifo_empty;
                    starve_d = '0;
                end
            end
            StForce: begin
                // Any A request presented while stalled is dropped.
                pop      = !fifo_empty;
                starve_d = '0;
                state_d  = StNormal;
            end
            default: begin
                state_d  = StNormal;
                starve_d = '0;
            end
        endcase

        if (pop) begin
            issue    = 1'b1;
            iss_addr = fifo_addr_q[rd_ptr_q];
            iss_data = fifo_data_q[rd_ptr_q];
            rd_ptr_d = PtrW'(rd_ptr_q + 1'b1);
        end

        // Entry written here only becomes visible to pop through count_q next cycle.
        if (push) begin
            fifo_addr_d[wr_ptr_q] = B_ADDR;
            fifo_data_d[wr_ptr_q] = B_DATA;
            wr_ptr_d              = PtrW'(wr_ptr_q + 1'b1);
        end
    end

    always_comb begin
        count_d    = count_q + CntW'(push) - CntW'(pop);
        w_on_d     = issue;
        waddr_d    = issue ? iss_addr : 4'd0;
        data_out_d = issue ? iss_data : 16'd0;
        endreg_d   = issue ? iss_addr : endreg_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StNormal;
            starve_q   <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            w_on_q     <= 1'b0;
            waddr_q    <= '0;
            data_out_q <= '0;
            endreg_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            w_on_q      <= w_on_d;
            waddr_q     <= waddr_d;
            data_out_q  <= data_out_d;
            endreg_q    <= endreg_d;
            fifo_addr_q <= fifo_addr_d;
            fifo_data_q <= fifo_data_d;
        end
    end

    assign B_READY  = b_ready;
    assign STALL    = (state_q == StForce);
    assign W_ON     = w_on_q;
    assign WADDR    = waddr_q;
    assign DATA_OUT = data_out_q;
    assign ENDWRITE = w_on_q;
    assign ENDREG   = endreg_q;

`ifdef REGARB_FORWARD_EN
    logic [PtrW-1:0] byp_idx;

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        BYP_HIT  = 1'b0;
        BYP_DATA = '0;
        byp_idx  = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            byp_idx = PtrW'(rd_ptr_q + PtrW'(i));
            if ((CntW'(i) < count_q) && (fifo_addr_q[byp_idx] == RADDR)) begin
                BYP_HIT  = 1'b1;
                BYP_DATA = fifo_data_q[byp_idx];
            end
        end
    end
`endif

endmodule
